// File: rtl/intra16_rebuild.sv
// Rebuilds one 16x16 VP8 luma macroblock: intra-16 prediction, Y2 inverse WHT,
// then one 4x4 inverse DCT per cycle added onto the prediction.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start             one-cycle request, honoured only while idle
//   x, y              macroblock position (0 = left/top edge unavailable for DC)
//   mode_i16          0=DC 1=TrueMotion 2=Vertical 3=Horizontal
//   top_left/top/left neighbour pixels, byte i = pixel i
//   dc_levels, dc_q   Y2 levels and dequant factors (raster order)
//   ac_levels, ac_q   Y1 levels per subblock and dequant factors
//   out               rebuilt pixels, byte 16r+c = row r, column c
//   busy, done        activity flag and one-cycle completion pulse
module intra16_rebuild (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [9:0]    x,
    input  logic [9:0]    y,
    input  logic [1:0]    mode_i16,
    input  logic [7:0]    top_left,
    input  logic [127:0]  top,
    input  logic [127:0]  left,
    input  logic [255:0]  dc_levels,
    input  logic [4095:0] ac_levels,
    input  logic [255:0]  dc_q,
    input  logic [255:0]  ac_q,
    output logic [2047:0] out,
    output logic          busy,
    output logic          done
);

    localparam int unsigned PIX_W  = 8;
    localparam int unsigned ACC_W  = 32;
    localparam int unsigned MB_PIX = 256;

    // 16 signed 32-bit coefficients of one 4x4 block, element k = raster index k
    typedef logic [15:0][ACC_W-1:0] blk_t;

    typedef enum logic [2:0] {IDLE, LOAD, PRED, WHT, IDCT, DONE} state_t;

    state_t state_q, state_d;

    logic [3:0]              sb_cnt_q;
    logic [9:0]              x_q, y_q;
    logic [1:0]              mode_q;
    logic [7:0]              tl_q;
    logic [127:0]            top_q, left_q;
    logic [255:0]            dcl_q, dcq_q, acq_q;
    logic [4095:0]           acl_q;
    logic [MB_PIX*PIX_W-1:0] pred_q;
    blk_t                    y2_q;

    logic [MB_PIX*PIX_W-1:0] pred_c;
    logic [MB_PIX*PIX_W-1:0] out_c;
    blk_t                    dq_c, coef_c, res_c;
    logic [255:0]            sb_lv_c;
    logic [11:0]             sum_t, sum_l;
    logic [7:0]              dc_val;
    logic [7:0]              pidx;

    function automatic logic [7:0] clip255(input logic signed [ACC_W-1:0] v);
        if (v < 0)          return 8'd0;
        if (v > 32'sd255)   return 8'd255;
        return v[7:0];
    endfunction

    // TrueMotion sum fits a signed 10-bit range (-255..510)
    function automatic logic [7:0] tm_pix(input logic [7:0] l, input logic [7:0] t,
                                          input logic [7:0] tl);
        logic signed [9:0] s;
        s = $signed({2'b00, l}) + $signed({2'b00, t}) - $signed({2'b00, tl});
        if (s < 0)          return 8'd0;
        if (s > 10'sd255)   return 8'd255;
        return s[7:0];
    endfunction

    // a + (a*20091 >>> 16); product widened so the shift sees the full value
    function automatic logic signed [ACC_W-1:0] mul1(input logic signed [ACC_W-1:0] a);
        logic signed [47:0] ae;
        logic signed [47:0] p;
        ae = {{16{a[ACC_W-1]}}, a};
        p  = ae * 48'sd20091;
        return a + 32'(p >>> 16);
    endfunction

    // a*35468 >>> 16
    function automatic logic signed [ACC_W-1:0] mul2(input logic signed [ACC_W-1:0] a);
        logic signed [47:0] ae;
        logic signed [47:0] p;
        ae = {{16{a[ACC_W-1]}}, a};
        p  = ae * 48'sd35468;
        return 32'(p >>> 16);
    endfunction

    function automatic blk_t inv_wht(input blk_t d);
        blk_t t;
        blk_t o;
        logic signed [ACC_W-1:0] a1, b1, c1, d1, a2, b2, c2, d2;
        t = '0;
        o = '0;
        for (int i = 0; i < 4; i++) begin
            a1 = $signed(d[i])     + $signed(d[12+i]);
            b1 = $signed(d[4+i])   + $signed(d[8+i]);
            c1 = $signed(d[4+i])   - $signed(d[8+i]);
            d1 = $signed(d[i])     - $signed(d[12+i]);
            t[i]    = a1 + b1;
            t[4+i]  = c1 + d1;
            t[8+i]  = a1 - b1;
            t[12+i] = d1 - c1;
        end
        for (int i = 0; i < 4; i++) begin
            a1 = $signed(t[4*i])   + $signed(t[4*i+3]);
            b1 = $signed(t[4*i+1]) + $signed(t[4*i+2]);
            c1 = $signed(t[4*i+1]) - $signed(t[4*i+2]);
            d1 = $signed(t[4*i])   - $signed(t[4*i+3]);
            a2 = a1 + b1;
            b2 = c1 + d1;
            c2 = a1 - b1;
            d2 = d1 - c1;
            o[4*i]   = (a2 + 32'sd3) >>> 3;
            o[4*i+1] = (b2 + 32'sd3) >>> 3;
            o[4*i+2] = (c2 + 32'sd3) >>> 3;
            o[4*i+3] = (d2 + 32'sd3) >>> 3;
        end
        return o;
    endfunction

    // Rounding bias of +4 folded into the DC term of each row pass
    function automatic blk_t idct4x4(input blk_t c);
        blk_t v;
        blk_t o;
        logic signed [ACC_W-1:0] a1, b1, c1, d1, e0;
        v = '0;
        o = '0;
        for (int j = 0; j < 4; j++) begin
            a1 = $signed(c[j]) + $signed(c[8+j]);
            b1 = $signed(c[j]) - $signed(c[8+j]);
            c1 = mul2($signed(c[4+j])) - mul1($signed(c[12+j]));
            d1 = mul1($signed(c[4+j])) + mul2($signed(c[12+j]));
            v[j]    = a1 + d1;
            v[4+j]  = b1 + c1;
            v[8+j]  = b1 - c1;
            v[12+j] = a1 - d1;
        end
        for (int i = 0; i < 4; i++) begin
            e0 = $signed(v[4*i]) + 32'sd4;
            a1 = e0 + $signed(v[4*i+2]);
            b1 = e0 - $signed(v[4*i+2]);
            c1 = mul2($signed(v[4*i+1])) - mul1($signed(v[4*i+3]));
            d1 = mul1($signed(v[4*i+1])) + mul2($signed(v[4*i+3]));
            o[4*i]   = (a1 + d1) >>> 3;
            o[4*i+1] = (b1 + c1) >>> 3;
            o[4*i+2] = (b1 - c1) >>> 3;
            o[4*i+3] = (a1 - d1) >>> 3;
        end
        return o;
    endfunction

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = LOAD;
            LOAD:    state_d = PRED;
            PRED:    state_d = WHT;
            WHT:     state_d = IDCT;
            IDCT:    if (sb_cnt_q == 4'd15) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // 16x16 prediction from the captured neighbours
    always_comb begin
        pred_c = '0;
        sum_t  = '0;
        sum_l  = '0;
        dc_val = 8'd128;
        for (int i = 0; i < 16; i++) begin
            sum_t = sum_t + 12'(top_q[8*i +: 8]);
            sum_l = sum_l + 12'(left_q[8*i +: 8]);
        end
        if (x_q != '0 && y_q != '0)
            dc_val = 8'((13'(sum_t) + 13'(sum_l) + 13'd16) >> 5);
        else if (x_q != '0)
            dc_val = 8'((sum_l + 12'd8) >> 4);
        else if (y_q != '0)
            dc_val = 8'((sum_t + 12'd8) >> 4);
        for (int r = 0; r < 16; r++) begin
            for (int c = 0; c < 16; c++) begin
                case (mode_q)
                    2'd0:    pred_c[(16*r+c)*8 +: 8] = dc_val;
                    2'd1:    pred_c[(16*r+c)*8 +: 8] = tm_pix(left_q[8*r +: 8], top_q[8*c +: 8], tl_q);
                    2'd2:    pred_c[(16*r+c)*8 +: 8] = top_q[8*c +: 8];
                    default: pred_c[(16*r+c)*8 +: 8] = left_q[8*r +: 8];
                endcase
            end
        end
    end

    // Y2 dequantisation: signed level times unsigned factor
    always_comb begin
        dq_c = '0;
        for (int i = 0; i < 16; i++) begin
            dq_c[i] = 32'($signed({{16{dcl_q[16*i+15]}}, dcl_q[16*i +: 16]}) *
                          $signed({16'b0, dcq_q[16*i +: 16]}));
        end
    end

    // Coefficients of the current subblock; slot 0 comes from the WHT
    always_comb begin
        sb_lv_c = acl_q[{sb_cnt_q, 8'd0} +: 256];
        coef_c  = '0;
        coef_c[0] = y2_q[sb_cnt_q];
        for (int k = 1; k < 16; k++) begin
            coef_c[k] = 32'($signed({{16{sb_lv_c[16*k+15]}}, sb_lv_c[16*k +: 16]}) *
                            $signed({16'b0, acq_q[16*k +: 16]}));
        end
        res_c = idct4x4(coef_c);
    end

    // Merge residual into the prediction for the 16 pixels of this subblock
    always_comb begin
        out_c = out;
        pidx  = '0;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                pidx = {sb_cnt_q[3:2], 2'(i), sb_cnt_q[1:0], 2'(j)};
                out_c[{pidx, 3'b000} +: 8] =
                    clip255($signed({24'b0, pred_q[{pidx, 3'b000} +: 8]}) + $signed(res_c[4*i+j]));
            end
        end
    end

    // State, datapath registers and outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            sb_cnt_q <= '0;
            x_q      <= '0;
            y_q      <= '0;
            mode_q   <= '0;
            tl_q     <= '0;
            top_q    <= '0;
            left_q   <= '0;
            dcl_q    <= '0;
            dcq_q    <= '0;
            acl_q    <= '0;
            acq_q    <= '0;
            pred_q   <= '0;
            y2_q     <= '0;
            out      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state_q <= state_d;
            busy    <= (state_d != IDLE);
            done    <= (state_d == DONE);
            case (state_q)
                LOAD: begin
                    x_q    <= x;
                    y_q    <= y;
                    mode_q <= mode_i16;
                    tl_q   <= top_left;
                    top_q  <= top;
                    left_q <= left;
                    dcl_q  <= dc_levels;
                    dcq_q  <= dc_q;
                    acl_q  <= ac_levels;
                    acq_q  <= ac_q;
                end
                PRED: pred_q <= pred_c;
                WHT:  y2_q   <= inv_wht(dq_c);
                IDCT: begin
                    out      <= out_c;
                    sb_cnt_q <= sb_cnt_q + 4'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_intra16_rebuild.sv
// Randomised self-checking bench for intra16_rebuild. Expected pixels come from
// a reference model that treats the WHT as a matrix product and the IDCT as a
// generic 1-D butterfly applied to columns then rows.
module tb_intra16_rebuild;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [9:0]    x, y;
    logic [1:0]    mode_i16;
    logic [7:0]    top_left;
    logic [127:0]  top, left;
    logic [255:0]  dc_levels, dc_q, ac_q;
    logic [4095:0] ac_levels;
    logic [2047:0] out;
    logic          busy, done;

    int n_checks = 0;
    int n_errors = 0;

    // Stimulus as plain integers; the model reads only these
    int s_x, s_y, s_mode, s_tl;
    int s_top [16];
    int s_left[16];
    int s_dcl [16];
    int s_dcq [16];
    int s_acq [16];
    int s_acl [16][16];
    int exp_px[256];

    intra16_rebuild dut (
        .clk(clk), .rst(rst), .start(start), .x(x), .y(y), .mode_i16(mode_i16),
        .top_left(top_left), .top(top), .left(left), .dc_levels(dc_levels),
        .ac_levels(ac_levels), .dc_q(dc_q), .ac_q(ac_q), .out(out),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int clip255(input longint v);
        if (v < 0)   return 0;
        if (v > 255) return 255;
        return int'(v);
    endfunction

    function automatic longint m1(input longint a);
        return a + ((a * 20091) >>> 16);
    endfunction

    function automatic longint m2(input longint a);
        return (a * 35468) >>> 16;
    endfunction

    task automatic idct1(input longint i0, input longint i1, input longint i2, input longint i3,
                         input longint bias,
                         output longint o0, output longint o1, output longint o2, output longint o3);
        longint a, b, c, d;
        a = i0 + bias + i2;
        b = i0 + bias - i2;
        c = m2(i1) - m1(i3);
        d = m1(i1) + m2(i3);
        o0 = a + d;
        o1 = b + c;
        o2 = b - c;
        o3 = a - d;
    endtask

    task automatic build_model();
        int     hm [4][4];
        int     pred [256];
        longint dq [4][4];
        longint tm [4][4];
        longint w  [4][4];
        longint y2 [16];
        longint cf [4][4];
        longint v  [4][4];
        longint rs [4][4];
        int     st, sl, dcv;
        hm = '{'{1, 1, 1, 1}, '{1, 1, -1, -1}, '{1, -1, -1, 1}, '{1, -1, 1, -1}};
        st = 0;
        sl = 0;
        for (int i = 0; i < 16; i++) begin
            st += s_top[i];
            sl += s_left[i];
        end
        if (s_x > 0 && s_y > 0) dcv = (st + sl + 16) >> 5;
        else if (s_x > 0)       dcv = (sl + 8) >> 4;
        else if (s_y > 0)       dcv = (st + 8) >> 4;
        else                    dcv = 128;
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 16; c++)
                case (s_mode)
                    0:       pred[16*r+c] = dcv;
                    1:       pred[16*r+c] = clip255(longint'(s_left[r] + s_top[c] - s_tl));
                    2:       pred[16*r+c] = s_top[c];
                    default: pred[16*r+c] = s_left[r];
                endcase
        // WHT = H * D * H^T, then rounding shift
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                dq[i][j] = longint'(s_dcl[4*i+j]) * longint'(s_dcq[4*i+j]);
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                tm[i][j] = 0;
                for (int k = 0; k < 4; k++) tm[i][j] += hm[i][k] * dq[k][j];
            end
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                w[i][j] = 0;
                for (int k = 0; k < 4; k++) w[i][j] += tm[i][k] * hm[j][k];
                y2[4*i+j] = (w[i][j] + 3) >>> 3;
            end
        for (int n = 0; n < 16; n++) begin
            for (int k = 0; k < 16; k++)
                cf[k/4][k%4] = (k == 0) ? y2[n] : longint'(s_acl[n][k]) * longint'(s_acq[k]);
            for (int j = 0; j < 4; j++)
                idct1(cf[0][j], cf[1][j], cf[2][j], cf[3][j], 0, v[0][j], v[1][j], v[2][j], v[3][j]);
            for (int i = 0; i < 4; i++)
                idct1(v[i][0], v[i][1], v[i][2], v[i][3], 4, rs[i][0], rs[i][1], rs[i][2], rs[i][3]);
            for (int i = 0; i < 4; i++)
                for (int j = 0; j < 4; j++)
                    exp_px[16*(4*(n/4)+i) + 4*(n%4) + j] =
                        clip255(longint'(pred[16*(4*(n/4)+i) + 4*(n%4) + j]) + (rs[i][j] >>> 3));
        end
    endtask

    task automatic drive();
        x        = 10'(s_x);
        y        = 10'(s_y);
        mode_i16 = 2'(s_mode);
        top_left = 8'(s_tl);
        for (int i = 0; i < 16; i++) begin
            top[8*i +: 8]        = 8'(s_top[i]);
            left[8*i +: 8]       = 8'(s_left[i]);
            dc_levels[16*i +: 16] = 16'(s_dcl[i]);
            dc_q[16*i +: 16]      = 16'(s_dcq[i]);
            ac_q[16*i +: 16]      = 16'(s_acq[i]);
            for (int k = 0; k < 16; k++) ac_levels[256*i+16*k +: 16] = 16'(s_acl[i][k]);
        end
    endtask

    task automatic scramble_ports();
        x        = 10'($urandom);
        y        = 10'($urandom);
        mode_i16 = 2'($urandom);
        top_left = 8'($urandom);
        for (int i = 0; i < 16; i++) begin
            top[8*i +: 8]         = 8'($urandom);
            left[8*i +: 8]        = 8'($urandom);
            dc_levels[16*i +: 16] = 16'($urandom);
            dc_q[16*i +: 16]      = 16'($urandom);
            ac_q[16*i +: 16]      = 16'($urandom);
        end
        for (int i = 0; i < 128; i++) ac_levels[32*i +: 32] = $urandom;
    endtask

    task automatic zero_stim();
        s_x = 0; s_y = 0; s_mode = 0; s_tl = 0;
        for (int i = 0; i < 16; i++) begin
            s_top[i] = 0; s_left[i] = 0; s_dcl[i] = 0;
            s_dcq[i] = int'($urandom_range(1, 60));
            s_acq[i] = int'($urandom_range(1, 60));
            for (int k = 0; k < 16; k++) s_acl[i][k] = 0;
        end
    endtask

    task automatic rand_stim();
        s_x    = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 1023));
        s_y    = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 1023));
        s_mode = int'($urandom_range(0, 3));
        s_tl   = int'($urandom_range(0, 255));
        for (int i = 0; i < 16; i++) begin
            s_top[i]  = int'($urandom_range(0, 255));
            s_left[i] = int'($urandom_range(0, 255));
            s_dcl[i]  = int'($urandom_range(0, 80)) - 40;
            s_dcq[i]  = int'($urandom_range(1, 60));
            s_acq[i]  = int'($urandom_range(1, 60));
            for (int k = 0; k < 16; k++)
                s_acl[i][k] = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 40)) - 20 : 0;
        end
    endtask

    task automatic check_rows(input string tag);
        logic [127:0] er;
        for (int r = 0; r < 16; r++) begin
            for (int c = 0; c < 16; c++) er[8*c +: 8] = 8'(exp_px[16*r+c]);
            check_val($sformatf("%s_row%0d", tag, r), out[128*r +: 128], er);
        end
    endtask

    // One full operation; dup_c > 0 pulses a second start in that cycle
    task automatic run_op(input string tag, input int dup_c);
        int done_at, done_cnt, busy_bad;
        drive();
        build_model();
        start = 1'b1;
        tick();
        start = 1'b0;
        done_at  = -1;
        done_cnt = 0;
        busy_bad = 0;
        for (int c = 1; c <= 24; c++) begin
            if (busy !== ((c <= 20) ? 1'b1 : 1'b0)) busy_bad++;
            if (done === 1'b1) begin
                done_cnt++;
                if (done_at < 0) done_at = c;
            end
            if (c == 20) check_rows(tag);
            if (c == 2) scramble_ports();
            start = (dup_c > 0 && c == dup_c) ? 1'b1 : 1'b0;
            tick();
        end
        start = 1'b0;
        check_val({tag, "_done_at"}, 128'(done_at), 128'(20));
        check_val({tag, "_done_cnt"}, 128'(done_cnt), 128'(1));
        check_val({tag, "_busy_bad"}, 128'(busy_bad), 128'(0));
        check_rows({tag, "_hold"});
    endtask

    initial begin
        int dcnt, bcnt;
        rst   = 1'b1;
        start = 1'b0;
        zero_stim();
        drive();
        repeat (3) tick();
        check_val("rst_busy", 128'(busy), 128'(0));
        check_val("rst_done", 128'(done), 128'(0));
        for (int r = 0; r < 16; r++) check_val($sformatf("rst_out_row%0d", r), out[128*r +: 128], 128'(0));
        rst = 1'b0;
        tick();

        // DC, no neighbours, no residual
        zero_stim();
        run_op("dc128", 0);

        // Vertical, top byte c = 16c
        zero_stim();
        s_mode = 2;
        for (int i = 0; i < 16; i++) s_top[i] = 16 * i;
        run_op("vert", 0);

        // Single Y2 level: +1 on every pixel
        zero_stim();
        s_dcl[0] = 8;
        s_dcq[0] = 8;
        run_op("dc129", 0);

        // TrueMotion saturating high
        zero_stim();
        s_mode = 1;
        for (int i = 0; i < 16; i++) begin s_top[i] = 250; s_left[i] = 250; end
        s_dcl[0] = 100;
        s_dcq[0] = 100;
        run_op("tm_clip", 0);

        // Second start during IDCT is ignored
        rand_stim();
        run_op("dup_start", 10);

        for (int t = 0; t < 10; t++) begin
            rand_stim();
            run_op($sformatf("rand%0d", t), 0);
        end

        // Reset in cycle T+10 aborts without a done pulse
        rand_stim();
        drive();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (9) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_val("abort_busy", 128'(busy), 128'(0));
        check_val("abort_done", 128'(done), 128'(0));
        for (int r = 0; r < 16; r++) check_val($sformatf("abort_out_row%0d", r), out[128*r +: 128], 128'(0));
        dcnt = 0;
        bcnt = 0;
        for (int c = 0; c < 24; c++) begin
            if (done === 1'b1) dcnt++;
            if (busy !== 1'b0) bcnt++;
            tick();
        end
        check_val("abort_no_done", 128'(dcnt), 128'(0));
        check_val("abort_idle", 128'(bcnt), 128'(0));

        // Reset wins over a simultaneous start
        rst   = 1'b1;
        start = 1'b1;
        tick();
        rst   = 1'b0;
        start = 1'b0;
        bcnt  = 0;
        for (int c = 0; c < 4; c++) begin
            if (busy !== 1'b0) bcnt++;
            tick();
        end
        check_val("rst_start_idle", 128'(bcnt), 128'(0));

        rand_stim();
        run_op("after_rst", 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/intra16_rebuild.md
INTRA16_REBUILD -- requirements
Module: intra16_rebuild

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port start, input, 1 bit: one-cycle request to rebuild one 16x16 luma macroblock; sampled only in IDLE.
REQ-004 SHALL have port x / y, input, 10 bits each: macroblock column/row; 0 means the left/top edge is unavailable for DC prediction.
REQ-005 SHALL have port mode_i16, input, 2 bits: 0=DC, 1=TrueMotion, 2=Vertical, 3=Horizontal.
REQ-006 SHALL have port top_left, input, 8 bits; top, input, 128 bits; left, input, 128 bits; byte i = pixel i (top: column i, left: row i), with edge substitution already done by the caller.
REQ-007 SHALL have port dc_levels, input, 256 bits: 16 signed 16-bit Y2 levels, raster order, entry i at [16i+15:16i].
REQ-008 SHALL have port ac_levels, input, 4096 bits: 16 subblocks x 16 signed 16-bit levels; subblock n, raster coefficient k at [256n+16k+15:256n+16k]; k=0 ignored.
REQ-009 SHALL have port dc_q / ac_q, input, 256 bits each: 16 unsigned 16-bit dequant factors, raster order (Y2 and Y1 matrices).
REQ-010 SHALL have port out, output, 2048 bits: rebuilt pixels, byte 16r+c = row r, column c.
REQ-011 SHALL have port busy, output, 1 bit; and port done, output, 1 bit, a one-cycle completion pulse.

Function
REQ-012 SHALL implement the FSM states IDLE, LOAD, PRED, WHT, IDCT, DONE.
REQ-013 IDLE SHALL go to LOAD on start=1; otherwise it SHALL stay in IDLE.
REQ-014 LOAD SHALL register all inputs; later input changes SHALL NOT affect the operation in progress.
REQ-015 LOAD SHALL then go to PRED, PRED to WHT, and WHT to IDCT.
REQ-016 IDCT SHALL process one 4x4 subblock per cycle, n = 0..15 in raster subblock order; a 4-bit counter SHALL wrap from 15 to 0 and go to DONE.
REQ-017 DONE SHALL pulse done=1 for exactly one cycle and return to IDLE.
REQ-018 Latency: start sampled in cycle T gives done=1 in cycle T+20.
REQ-019 busy SHALL be 1 in every state except IDLE.
REQ-020 start while busy=1 SHALL be ignored, with no queuing.
REQ-021 out SHALL update only during IDCT and SHALL hold its value from DONE until the next operation's IDCT.
REQ-022 PRED, DC mode, with T=sum(top) and L=sum(left):
  - x>0, y>0: (T+L+16)>>5
  - y=0, x>0: (L+8)>>4
  - x=0, y>0: (T+8)>>4
  - x=0, y=0: 128
REQ-023 PRED, TrueMotion: pred[r][c] = clip255(left[r]+top[c]-top_left), computed signed in 10 bits.
REQ-024 PRED, Vertical: pred[r][c] = top[c]. Horizontal: pred[r][c] = left[r].
REQ-025 WHT SHALL dequantize d[i] = dc_levels[i]*dc_q[i] as a signed 32-bit product.
REQ-026 WHT SHALL apply the VP8 inverse Walsh-Hadamard transform: vertical pass, then horizontal pass; each output = (v+3)>>>3, arithmetic shift.
REQ-027 WHT output i SHALL become coefficient 0 of subblock i.
REQ-028 IDCT, subblock n: coefficients k=1..15 SHALL be ac_levels[n][k]*ac_q[k], signed 32-bit.
REQ-029 IDCT SHALL apply the VP8 inverse DCT using MUL1(a) = a + ((a*20091)>>>16) and MUL2(a) = (a*35468)>>>16.
REQ-030 IDCT: vertical pass, then horizontal pass with +4 added to the DC term; residual = v>>>3.
REQ-031 IDCT: out pixel = clip255(pred + residual), saturating to 0..255.
REQ-032 All intermediates SHALL be at least 32-bit signed; no overflow is required to be handled beyond 32 bits.

Reset
REQ-033 rst=1 at any clock edge SHALL force IDLE, busy=0, done=0, out=0, subblock counter=0 and all internal registers to 0.
REQ-034 rst asserted mid-operation SHALL abort that operation with no done pulse.
REQ-035 rst asserted in the same cycle as start SHALL take priority, so that start is ignored.

Verification
REQ-036 mode=0, x=0, y=0, all levels 0 -> done at T+20; all 256 out bytes = 128.
REQ-037 mode=2, top byte c = 16c, all levels 0 -> out[r][c] = 16c for every r.
REQ-038 mode=0, x=0, y=0, dc_levels[0]=8, dc_q[0]=8, all other levels 0 -> WHT gives 8 per subblock; every out byte = 129.
REQ-039 mode=1, top_left=0, top=250 everywhere, left=250 everywhere, dc_levels[0]=100, dc_q[0]=100 -> every out byte = 255 (clip high).
REQ-040 Second start pulsed during IDCT -> ignored; exactly one done pulse; busy high from T+1 to T+20.
REQ-041 rst asserted at T+10 -> next cycle busy=0, out=0; no done pulse; a new start afterwards completes normally.
